regfile: RTL and testbench
==========================

Name: regfile

Overview:
- Multi-ported general-purpose register file for the tinyproc datapath.
- Two independent combinational read ports (A, B) feed the ALU operands.
- One synchronous write port (C) takes the write-back result.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of DinC/DoA/DoB.
- ADDR_W, 5, address width; depth = 2**ADDR_W (32 registers).

Ports:
- clk  input  1  clock; write occurs on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all registers.
- AddrA  input  ADDR_W  read port A address.
- AddrB  input  ADDR_W  read port B address.
- AddrC  input  ADDR_W  write port C address.
- DinC  input  DATA_W  write data for port C.
- DoA  output  DATA_W  read data for AddrA.
- DoB  output  DATA_W  read data for AddrB.
- wrback  input  1  write enable for port C; active high.

Behaviour:
- Storage: 2**ADDR_W words of DATA_W bits, indices 0..2**ADDR_W-1.
- Reset:
  - rst_n low immediately clears every register to 0, independent of clk.
  - DoA and DoB read 0 while reset is held.
  - Reset deassertion is synchronised by the surrounding system; no internal sync.
  - Reset asserted mid-cycle discards any pending write.
- Write:
  - On rising clk with rst_n high and wrback high, reg[AddrC] <= DinC.
  - wrback low means no register changes.
  - Address and data are sampled only at the edge; changes between edges have no effect.
- Register 0:
  - Writes to address 0 are ignored.
  - Reads of address 0 always return 0.
- Read:
  - Purely combinational, zero latency: DoA = reg[AddrA], DoB = reg[AddrB].
  - Outputs track address changes within the same cycle.
  - A value written at edge N is visible on the read ports immediately after edge N.
- AddrA == AddrB is legal; both ports return the same value.
- Read/write collision (AddrA or AddrB equals AddrC with wrback high, before the edge):
  - Default: the read returns the old stored value.
  - See Optional Feature for the alternative.
- Data is treated as raw bits; no sign handling. Negative values are stored in two's complement.
- No X propagation on outputs after reset; all addresses are in range by construction.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding on each read port. If wrback = 1, AddrC != 0 and AddrX == AddrC, then DoX = DinC combinationally.
  - This lets a same-cycle reader observe the value being written.
  - Reset still forces outputs to 0 while rst_n is low.
- Not defined:
  - No forwarding; reads return only the stored contents.
  - The new value appears after the clock edge.

Test Plan:
- Reset: pulse rst_n low with no clk edge, then read all 32 addresses on both ports -> every DoA/DoB = 0x00000000.
- Write r1: wrback=1, AddrC=1, DinC=-2540, rising edge; AddrA=2, AddrB=1 -> DoB=0xFFFFF614, DoA=0x00000000.
- Write r2: AddrC=2, DinC=2550, edge -> DoA=0x000009F6, DoB=0xFFFFF614.
- Write-back of sum: DinC=DoA+DoB, AddrC=4, edge, then AddrA=4 -> DoA=0x0000000A. Subsequent edges with the same inputs keep r4=0x0000000A and r1/r2 unchanged.
- Write disable and r0:
  - wrback=0, AddrC=1, DinC=0x12345678, edge -> r1 still 0xFFFFF614.
  - wrback=1, AddrC=0, DinC=0xDEADBEEF, edge -> DoA for AddrA=0 is 0.
- Collision and async reset:
  - AddrA=AddrC=3, wrback=1, DinC=0x55AA55AA before the edge -> DoA=0 without REGFILE_BYPASS_EN; DoA=0x55AA55AA with it.
  - After the edge -> 0x55AA55AA in both builds.
  - rst_n low between edges -> r3 reads 0 immediately.

Source files
------------

// File: rtl/regfile.sv
// regfile: general-purpose register file for the tinyproc datapath.
//
// Two combinational read ports (A, B) and one synchronous write port (C).
// Register 0 is hardwired to zero. Writes to it are dropped, and reads of it return 0.
//
// Parameters:
//   DATA_W  width of each register and of DinC/DoA/DoB (default 32)
//   ADDR_W  address width; depth = 2**ADDR_W (default 5 -> 32 registers)
//
// Ports:
//   clk     clock; write on rising edge
//   rst_n   asynchronous active-low reset; clears every register
//   AddrA   read port A address      -> DoA
//   AddrB   read port B address      -> DoB
//   AddrC   write port C address
//   DinC    write data for port C
//   wrback  write enable for port C (active high)
//   DoA     read data for AddrA
//   DoB     read data for AddrB
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, each read port forwards DinC combinationally
//                      when wrback is high, AddrC is non-zero and the read address
//                      equals AddrC. Otherwise a read returns only the stored contents.
module regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [ADDR_W-1:0] AddrC,
    input  logic [DATA_W-1:0] DinC,
    output logic [DATA_W-1:0] DoA,
    output logic [DATA_W-1:0] DoB,
    input  logic              wrback
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_valid;

    assign wr_valid = wrback && (AddrC != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (wr_valid) begin
            mem[AddrC] <= DinC;
        end
    end

    // Read ports. Address 0 is forced to zero explicitly and does not rely on mem[0].
    // The output is also held at zero while reset is asserted, so that forwarding
    // cannot leak DinC during reset.
    always_comb begin
        DoA = mem[AddrA];
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && (AddrA == AddrC)) begin
            DoA = DinC;
        end
`endif
        if ((AddrA == '0) || !rst_n) begin
            DoA = '0;
        end
    end

    always_comb begin
        DoB = mem[AddrB];
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && (AddrB == AddrC)) begin
            DoB = DinC;
        end
`endif
        if ((AddrB == '0) || !rst_n) begin
            DoB = '0;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile (default parameters).
// Expected values follow the REGFILE_BYPASS_EN setting of the build.
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  AddrA;
    logic [4:0]  AddrB;
    logic [4:0]  AddrC;
    logic [31:0] DinC;
    logic [31:0] DoA;
    logic [31:0] DoB;
    logic        wrback;

    int unsigned checks;
    int unsigned failures;

    regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .AddrA  (AddrA),
        .AddrB  (AddrB),
        .AddrC  (AddrC),
        .DinC   (DinC),
        .DoA    (DoA),
        .DoB    (DoB),
        .wrback (wrback)
    );

    // One full clock cycle. Rising edge first, and the task returns with clk low.
    task automatic tick();
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #5;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] sum;
    logic [31:0] coll_exp;

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_n    = 1'b1;
        AddrA    = '0;
        AddrB    = '0;
        AddrC    = '0;
        DinC     = '0;
        wrback   = 1'b0;

`ifdef REGFILE_BYPASS_EN
        coll_exp = 32'h55AA_55AA;
`else
        coll_exp = 32'h0000_0000;
`endif

        // Reset pulse without any clock edge, then sweep every address on both ports.
        #2;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            AddrA = 5'(i);
            AddrB = 5'(31 - i);
            #1;
            check($sformatf("reset_a%0d", i), DoA, 32'h0);
            check($sformatf("reset_b%0d", 31 - i), DoB, 32'h0);
        end

        // r1 = -2540
        wrback = 1'b1;
        AddrC  = 5'd1;
        DinC   = 32'hFFFF_F614;
        tick();
        AddrA = 5'd2;
        AddrB = 5'd1;
        #1;
        check("r1_b", DoB, 32'hFFFF_F614);
        check("r2_empty_a", DoA, 32'h0);

        // r2 = 2550
        AddrC = 5'd2;
        DinC  = 32'h0000_09F6;
        tick();
        check("r2_a", DoA, 32'h0000_09F6);
        check("r1_b_again", DoB, 32'hFFFF_F614);

        // Write back the sum (-2540 + 2550 = 10) into r4. The remaining edges keep the same inputs.
        sum   = DoA + DoB;
        AddrC = 5'd4;
        DinC  = sum;
        tick();
        tick();
        tick();
        wrback = 1'b0;
        AddrA  = 5'd4;
        #1;
        check("r4_sum", DoA, 32'h0000_000A);
        AddrA = 5'd1;
        AddrB = 5'd2;
        #1;
        check("r1_kept", DoA, 32'hFFFF_F614);
        check("r2_kept", DoB, 32'h0000_09F6);

        // Disabled write leaves r1 untouched.
        wrback = 1'b0;
        AddrC  = 5'd1;
        DinC   = 32'h1234_5678;
        tick();
        check("wr_disabled", DoA, 32'hFFFF_F614);

        // A write to r0 is dropped. With forwarding enabled, r0 must still read 0 before the edge.
        wrback = 1'b1;
        AddrC  = 5'd0;
        DinC   = 32'hDEAD_BEEF;
        AddrA  = 5'd0;
        AddrB  = 5'd0;
        #1;
        check("r0_pre_edge", DoA, 32'h0);
        tick();
        check("r0_a", DoA, 32'h0);
        check("r0_b", DoB, 32'h0);

        // Top address.
        AddrC = 5'd31;
        DinC  = 32'h8000_0001;
        tick();
        wrback = 1'b0;
        AddrA  = 5'd31;
        #1;
        check("r31", DoA, 32'h8000_0001);

        // Read/write collision on r3. AddrB watches an unrelated register.
        AddrA  = 5'd3;
        AddrB  = 5'd5;
        AddrC  = 5'd3;
        DinC   = 32'h55AA_55AA;
        wrback = 1'b1;
        #1;
        check("collide_pre", DoA, coll_exp);
        check("collide_other", DoB, 32'h0);
        // A data change between edges must not matter. Only the value at the edge is stored.
        DinC = 32'h0F0F_0F0F;
        #1;
        DinC = 32'h55AA_55AA;
        tick();
        wrback = 1'b0;
        #1;
        check("collide_post", DoA, 32'h55AA_55AA);
        AddrB = 5'd3;
        #1;
        check("same_addr_b", DoB, 32'h55AA_55AA);

        // Mid-cycle reset: outputs drop immediately, and the write pending on r6 is discarded.
        wrback = 1'b1;
        AddrC  = 5'd6;
        DinC   = 32'hCAFE_F00D;
        AddrB  = 5'd6;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_r3", DoA, 32'h0);
        check("rst_bypass_b", DoB, 32'h0);
        tick();
        wrback = 1'b0;
        rst_n  = 1'b1;
        #1;
        check("rst_r3_after", DoA, 32'h0);
        check("rst_r6_discard", DoB, 32'h0);
        AddrA = 5'd1;
        AddrB = 5'd31;
        #1;
        check("rst_r1", DoA, 32'h0);
        check("rst_r31", DoB, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
